// File: rtl/burst_target.sv
// Burst-side responder: stores written beats in a local register array and streams them back on read.
// Optional define BT_READY_THROTTLE_EN gates in_ready with a free-running toggle for 50% write backpressure.
module burst_target #(
  parameter int ADDR_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bt_start,
  input  logic       bt_rw,
  input  logic [7:0] bt_length,
  input  logic [7:0] bt_max_burst_size,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       bt_idle,
  output logic       bt_done,
  output logic       bt_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_RECV = 2'd1,
    RD_SEND = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [7:0]        remaining;
  logic [7:0]        beat_cnt;
  logic [7:0]        max_burst;
  logic [7:0]        mem [2**ADDR_W];
  logic              exp_last;
  logic              wr_fire;
  logic              rd_fire;

`ifdef BT_READY_THROTTLE_EN
  logic toggle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) toggle <= 1'b0;
    else        toggle <= ~toggle;
  end

  assign in_ready = (state == WR_RECV) && toggle;
`else
  assign in_ready = (state == WR_RECV);
`endif

  assign out_valid = (state == RD_SEND);
  assign bt_idle   = (state == IDLE);
  assign bt_done   = (state == DONE);

  // A beat closes its burst either at the burst size limit or at the end of the transaction.
  assign exp_last = ((max_burst != 8'd0) && (beat_cnt == max_burst - 8'd1)) ||
                    (remaining == 8'd1);

  assign wr_fire  = in_valid && in_ready;
  assign rd_fire  = out_valid && out_ready;
  assign out_data = mem[ptr];
  assign out_last = out_valid && exp_last;

  // Direction is carried by the state itself, so bt_rw needs no separate register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= 8'd0;
      beat_cnt  <= 8'd0;
      max_burst <= 8'd0;
      bt_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bt_start) begin
            ptr       <= '0;
            remaining <= bt_length;
            beat_cnt  <= 8'd0;
            max_burst <= bt_max_burst_size;
            bt_err    <= 1'b0;
            if (bt_length == 8'd0) state <= DONE;
            else if (bt_rw)        state <= WR_RECV;
            else                   state <= RD_SEND;
          end
        end
        WR_RECV: begin
          if (wr_fire) begin
            ptr       <= ptr + 1'b1;
            remaining <= remaining - 8'd1;
            beat_cnt  <= exp_last ? 8'd0 : beat_cnt + 8'd1;
            if (in_last != exp_last) bt_err <= 1'b1;
            if (remaining == 8'd1)   state  <= DONE;
          end
        end
        RD_SEND: begin
          if (rd_fire) begin
            ptr       <= ptr + 1'b1;
            remaining <= remaining - 8'd1;
            beat_cnt  <= exp_last ? 8'd0 : beat_cnt + 8'd1;
            if (remaining == 8'd1) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is deliberately left out of reset; a mis-framed beat is still stored.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[ptr] <= in_data;
  end

endmodule

// File: doc/burst_target.md
Name: burst_target

Overview:
- Responder at the far end of the 8-bit valid/ready/last burst interface used by the data burst controller.
- In write direction it receives burst beats and stores them in a local 2^ADDR_W x 8 register-array memory.
- In read direction it sends stored bytes back as beats, split into bursts of at most max_burst_size.
- Used as a bus-functional target and loopback endpoint for burst-side integration and verification.

Parameters:
ADDR_W, 8, memory address width; depth = 2^ADDR_W (256 at default).

Ports:
clk  in  1  global clock
rst_n  in  1  reset, asynchronous, active-low
bt_start  in  1  transaction start; sampled only in IDLE
bt_rw  in  1  1 = target receives (write), 0 = target sends (read)
bt_length  in  8  total beats; 0 = empty transaction
bt_max_burst_size  in  8  beats per burst; 0 = no intermediate bursts
in_valid  in  1  write beat valid
in_data  in  8  write beat data
in_last  in  1  write beat is last of its burst
in_ready  out  1  target accepts write beat
out_valid  out  1  read beat valid
out_data  out  8  read beat data
out_last  out  1  read beat is last of its burst
out_ready  in  1  initiator accepts read beat
bt_idle  out  1  high when no transaction is in progress
bt_done  out  1  one-cycle pulse at transaction end
bt_err  out  1  sticky flag for a burst framing mismatch on write

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - in_ready = 0, out_valid = 0, out_last = 0, bt_done = 0, bt_err = 0, bt_idle = 1.
  - Pointer, remaining and beat counters cleared.
  - Memory contents are not reset.
- Beat transfer: occurs on a rising edge where valid & ready are both high.
- FSM states and transitions:
  - IDLE -> WR_RECV on bt_start & bt_rw.
  - IDLE -> RD_SEND on bt_start & ~bt_rw.
  - IDLE -> DONE instead if bt_length == 0 at start (no beats transferred).
  - WR_RECV -> DONE on the edge that transfers the beat making remaining == 0.
  - RD_SEND -> DONE likewise.
  - DONE -> IDLE unconditionally.
- Configuration latch at the start edge:
  - bt_rw, bt_length and bt_max_burst_size are latched.
  - Pointer = 0, remaining = bt_length, beat_cnt = 0.
  - bt_err is cleared.
  - bt_idle drops.
- Handshake signals:
  - in_ready is high throughout WR_RECV (see Optional Feature) and low in every other state.
  - out_valid is high throughout RD_SEND and low in every other state.
- Write path: each transfer writes mem[ptr] = in_data, then ptr+1, remaining-1, beat_cnt+1.
- Read path:
  - out_data = mem[ptr], read combinationally.
  - out_data and out_last stay stable while out_valid & ~out_ready.
  - Each transfer does ptr+1, remaining-1, beat_cnt+1.
- Expected last: beat_cnt == max-1 (max != 0) or remaining == 1.
  - On transfer, beat_cnt resets to 0 when the beat is an expected last.
  - Read: out_last = expected last.
  - Write: if in_last != expected last on a transfer, set bt_err; bt_err holds until the next accepted start. The beat is still stored.
- Arithmetic widths:
  - ptr is ADDR_W bits and wraps modulo 2^ADDR_W.
  - remaining and beat_cnt are 8 bits.
  - bt_length == 256 is not expressible; 0 means empty.
- Outputs in DONE:
  - bt_done = 1 for exactly one cycle.
  - bt_idle stays low in DONE and returns high in IDLE.
- bt_start while not in IDLE is ignored.
- Write-then-read with the same length returns the written bytes in order.
- Latency:
  - Start at edge N: in_ready or out_valid is high in the cycle after N.
  - Final transfer at edge M: bt_done is high in the cycle after M; IDLE and bt_idle = 1 one cycle later.
- Reset mid-transaction: immediate return to the reset values above; the partial transfer is discarded (memory may hold partial data).

Optional Feature:
BT_READY_THROTTLE_EN:
- Defined:
  - A free-running toggle bit (reset 0) flips every cycle.
  - in_ready = (state == WR_RECV) & toggle, giving 50% backpressure.
  - The write transfer count, ordering and framing rules are unchanged.
- Undefined: in_ready is high for the whole of WR_RECV.

Test Plan:
- Write 4 beats: bt_rw=1, length=4, max=2, data 0x11,0x22,0x33,0x44, in_last on beats 2 and 4 -> done pulse, err=0, mem[0..3] = 11,22,33,44.
- Loopback read: after the previous test, bt_rw=0, length=4, max=2, out_ready=1 -> out_data 11,22,33,44, out_last on beats 2 and 4, done pulse one cycle after beat 4.
- Read backpressure: length=3, max=0, out_ready pattern 1,0,0,1,1 -> out_data/out_last held during stalls; out_last only on beat 3; exactly 3 transfers.
- Framing error: write length=3, max=2, in_last only on beat 3 -> bt_err=1 after beat 2 and stays high; next start clears it.
- Corner cases:
  - length=0 -> DONE the cycle after start; no in_ready or out_valid; bt_done pulses.
  - bt_start during WR_RECV is ignored.
- Reset mid-write after 2 of 5 beats -> all outputs at reset values; next write of length=2 stores at mem[0..1].
